// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - ADD/SUB/ADDI encoder with address tagging and a 2-entry output FIFO.
// Optional macro INST_ENC_RANGE_CHECK_EN: ADDI immediates outside -2048..2047 are treated as illegal.
module inst_encoder #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_imm,
  input  logic [3:0]  alu_control,
  input  logic [4:0]  rs1_num,
  input  logic [4:0]  rs2_num,
  input  logic [4:0]  rd_num,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [3:0]  ALU_ADD = 4'b0010;
  localparam logic [3:0]  ALU_SUB = 4'b0100;
  localparam logic [6:0]  OP_R    = 7'h33;
  localparam logic [6:0]  OP_I    = 7'h13;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [1:0]  count;
  logic [31:0] slot0_inst, slot0_addr;
  logic [31:0] slot1_inst, slot1_addr;
  logic [31:0] addr_q;
  logic        err_q;
  logic [7:0]  err_cnt_q;

  logic        range_bad;
  logic        illegal;
  logic [31:0] enc;
  logic        push, pop;

`ifdef INST_ENC_RANGE_CHECK_EN
  assign range_bad = (imm[31:11] != {21{imm[11]}});
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:12];
  assign range_bad = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    enc     = NOP;
    if (is_imm) begin
      if (alu_control != ALU_ADD || range_bad)
        illegal = 1'b1;
      else
        enc = {imm[11:0], rs1_num, 3'b000, rd_num, OP_I};
    end else begin
      if (alu_control == ALU_ADD)
        enc = {7'h00, rs2_num, rs1_num, 3'b000, rd_num, OP_R};
      else if (alu_control == ALU_SUB)
        enc = {7'h20, rs2_num, rs1_num, 3'b000, rd_num, OP_R};
      else
        illegal = 1'b1;
    end
  end

  // Readiness comes only from occupancy so out_ready never reaches in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      slot0_inst <= 32'h0;
      slot0_addr <= 32'h0;
      slot1_inst <= 32'h0;
      slot1_addr <= 32'h0;
      addr_q     <= START_ADDR;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else if (clear) begin
      count     <= 2'd0;
      addr_q    <= START_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      if (push) begin
        addr_q <= addr_q + 32'd4;
        if (illegal) begin
          err_q <= 1'b1;
          if (err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
      // slot0 is always the head; slot1 only holds the second entry.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0_inst <= enc;
            slot0_addr <= addr_q;
          end else begin
            slot1_inst <= enc;
            slot1_addr <= addr_q;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0_inst <= slot1_inst;
          slot0_addr <= slot1_addr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0_inst <= enc;
            slot0_addr <= addr_q;
          end else begin
            slot0_inst <= slot1_inst;
            slot0_addr <= slot1_addr;
            slot1_inst <= enc;
            slot1_addr <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst      = slot0_inst;
  assign inst_addr = slot0_addr;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder: vector table, corner sequences, random vs queue model.
module tb_inst_encoder;

  localparam logic [31:0] S0 = 32'h0000_0000;
  localparam logic [31:0] SH = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready, is_imm;
  logic [3:0]  alu_control;
  logic [4:0]  rs1_num, rs2_num, rd_num;
  logic [31:0] imm;
  logic        in_ready, out_valid, err;
  logic [31:0] inst, inst_addr;
  logic [7:0]  err_count;
  logic        h_in_ready, h_out_valid, h_err;
  logic [31:0] h_inst, h_inst_addr;
  logic [7:0]  h_err_count;

  always #5 clk = ~clk;

  inst_encoder #(.START_ADDR(S0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .is_imm(is_imm), .alu_control(alu_control), .rs1_num(rs1_num), .rs2_num(rs2_num),
    .rd_num(rd_num), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .inst_addr(inst_addr), .err(err), .err_count(err_count));

  inst_encoder #(.START_ADDR(SH)) dut_hi (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(h_in_ready),
    .is_imm(is_imm), .alu_control(alu_control), .rs1_num(rs1_num), .rs2_num(rs2_num),
    .rd_num(rd_num), .imm(imm), .out_valid(h_out_valid), .out_ready(out_ready),
    .inst(h_inst), .inst_addr(h_inst_addr), .err(h_err), .err_count(h_err_count));

  typedef struct {
    logic        is_imm;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] exp_inst;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  vec_t tbl[8];
  ent_t q[$];
  logic [31:0] m_addr;
  bit          m_err, m_zero;
  int          m_cnt;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(logic im, logic [3:0] alu, logic [4:0] r1, logic [4:0] r2,
                                          logic [4:0] rd, logic [31:0] iv, output bit bad);
    int sv;
    sv  = $signed(iv);
    bad = 0;
    if (im) begin
      if (alu != 4'd2) bad = 1;
`ifdef INST_ENC_RANGE_CHECK_EN
      if (sv < -2048 || sv > 2047) bad = 1;
`endif
    end else if (alu != 4'd2 && alu != 4'd4) bad = 1;
    if (bad) return 32'h13;
    if (im) return (iv & 32'hFFF) * 32'h10_0000 + r1 * 32'h8000 + rd * 32'h80 + 32'h13;
    return ((alu == 4'd4) ? 32'h4000_0000 : 32'h0) + r2 * 32'h10_0000 + r1 * 32'h8000 + rd * 32'h80 + 32'h33;
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = S0;
    m_err  = 0;
    m_cnt  = 0;
    m_zero = 1;
  endtask

  task automatic set_req(logic im, logic [3:0] alu, logic [4:0] r1, logic [4:0] r2,
                         logic [4:0] rd, logic [31:0] iv);
    is_imm = im; alu_control = alu; rs1_num = r1; rs2_num = r2; rd_num = rd; imm = iv;
  endtask

  // Compare DUT against the model, advance the model for this edge, then step one clock.
  task automatic cycle();
    bit          ill, push, pop;
    logic [31:0] e;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("err", err, m_err);
    chk("err_count", err_count, m_cnt);
    if (q.size() > 0) begin
      chk("inst", inst, q[0].inst);
      chk("inst_addr", inst_addr, q[0].addr);
    end else if (m_zero) begin
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_addr", inst_addr, 32'h0);
    end
    if (!rst_n) model_reset();
    else if (clear) begin
      q.delete(); m_addr = S0; m_err = 0; m_cnt = 0;
    end else begin
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        e = ref_enc(is_imm, alu_control, rs1_num, rs2_num, rd_num, imm, ill);
        q.push_back('{inst: e, addr: m_addr});
        m_addr += 32'd4;
        m_zero = 0;
        if (ill) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_seq();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    set_req(0, 4'd2, 5'd0, 5'd0, 5'd0, 32'h0);
    reset_seq();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_inst", inst, 32'h0);
    chk("reset_err_count", err_count, 8'h00);

    tbl[0] = '{0, 4'b0010, 5'd1, 5'd2, 5'd3, 32'h0, 32'h002081B3};
    tbl[1] = '{0, 4'b0100, 5'd6, 5'd7, 5'd5, 32'h0, 32'h407302B3};
    tbl[2] = '{1, 4'b0010, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFF00093};
`ifdef INST_ENC_RANGE_CHECK_EN
    tbl[3] = '{1, 4'b0010, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h00000013};
`else
    tbl[3] = '{1, 4'b0010, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h80000093};
`endif
    tbl[4] = '{0, 4'b1111, 5'd1, 5'd2, 5'd3, 32'h0, 32'h00000013};
    tbl[5] = '{1, 4'b0100, 5'd1, 5'd2, 5'd3, 32'd5, 32'h00000013};
    tbl[6] = '{1, 4'b0010, 5'd2, 5'd9, 5'd10, 32'd100, 32'h06410513};
    tbl[7] = '{0, 4'b0010, 5'd31, 5'd31, 5'd31, 32'h0, 32'h01FF8FB3};

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].is_imm, tbl[i].alu, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("tbl_inst", inst, tbl[i].exp_inst);
      chk("tbl_addr", inst_addr, S0 + 32'(4 * i));
      cycle();
    end

    // Backpressure: two accepts fill the FIFO, the third waits, drain keeps order.
    clear = 1'b1; cycle(); clear = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(0, 4'd2, 5'd1, 5'd1, 5'd1, 32'h0); cycle();
    set_req(0, 4'd4, 5'd2, 5'd2, 5'd2, 32'h0); cycle();
    set_req(1, 4'd2, 5'd3, 5'd3, 5'd3, 32'd7);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_head_addr", inst_addr, S0);
    cycle(); cycle();
    out_ready = 1'b1;
    cycle(); cycle();
    in_valid = 1'b0;
    chk("bp_third_addr_pending", q.size() > 0 ? q[q.size()-1].addr : 32'hDEAD, S0 + 32'd8);
    repeat (3) cycle();

    // 300 illegal requests saturate the counter; clear drops the concurrent request.
    set_req(0, 4'b1111, 5'd1, 5'd2, 5'd3, 32'h0);
    in_valid = 1'b1;
    repeat (300) cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_err", err, 1'b1);
    in_valid = 1'b1; clear = 1'b1; cycle();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_err", err, 1'b0);
    chk("clr_err_count", err_count, 8'h00);
    chk("clr_out_valid", out_valid, 1'b0);
    set_req(0, 4'd2, 5'd4, 5'd5, 5'd6, 32'h0);
    in_valid = 1'b1; cycle(); in_valid = 1'b0;
    chk("clr_first_addr", inst_addr, S0);
    cycle();

    // Address wrap on the high-start instance.
    reset_seq();
    out_ready = 1'b1; in_valid = 1'b1;
    set_req(0, 4'd2, 5'd1, 5'd2, 5'd3, 32'h0);
    cycle(); chk("wrap_addr0", h_inst_addr, 32'hFFFF_FFF8);
    cycle(); chk("wrap_addr1", h_inst_addr, 32'hFFFF_FFFC);
    cycle(); chk("wrap_addr2", h_inst_addr, 32'h0000_0000);
    in_valid = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      case ($urandom_range(0, 3))
        0, 1: a = 4'd2;
        2: a = 4'd4;
        default: a = 4'($urandom);
      endcase
      set_req(1'($urandom), a, 5'($urandom), 5'($urandom), 5'($urandom),
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: START_ADDR, 32'h0000_0000, address assigned to the first instruction after reset or clear.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 clear  input  1  synchronous flush of buffer and address counter.
REQ-005 in_valid  input  1  request carries a valid instruction description.
REQ-006 in_ready  output  1  encoder can accept a request this cycle.
REQ-007 is_imm  input  1  1 = I-type (opcode 0x13), 0 = R-type (opcode 0x33).
REQ-008 alu_control  input  4  4'b0010 = ADD/ADDI, 4'b0100 = SUB (R-type only).
REQ-009 rs1_num, rs2_num, rd_num  input  5 each  register fields; rs2_num ignored when is_imm=1.
REQ-010 imm  input  32  signed immediate for I-type.
REQ-011 out_valid  output  1  head buffer entry valid.
REQ-012 out_ready  input  1  consumer takes head entry when out_valid && out_ready.
REQ-013 inst  output  32  encoded instruction at head.
REQ-014 inst_addr  output  32  address paired with head instruction.
REQ-015 err  output  1  sticky: an illegal request has been accepted since last reset/clear.
REQ-016 err_count  output  8  saturating count of illegal requests accepted.

Function
REQ-017 Request accepted on an edge where in_valid && in_ready; response is an entry in a 2-entry FIFO, out_valid high the cycle after acceptance (1-cycle latency).
REQ-018 in_ready = (FIFO occupancy < 2), purely from registered state; no combinational path from out_ready.
REQ-019 Push and pop in the same cycle with occupancy 1 keeps occupancy 1 and order preserved; pop with occupancy 0 impossible (out_valid low).
REQ-020 R-type ADD encoding: {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; SUB: {7'h20, rs2, rs1, 3'b000, rd, 7'h33}.
REQ-021 ADDI encoding: {imm[11:0], rs1, 3'b000, rd, 7'h13}.
REQ-022 Illegal request (alu_control not in REQ-008 set, or is_imm=1 with alu_control=4'b0100) is accepted, emits NOP 32'h0000_0013, sets err, increments err_count.
REQ-023 Each accepted request (legal or not) is tagged with the current address counter; counter then advances by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 err_count saturates at 8'hFF; further errors leave it at 8'hFF.
REQ-025 inst and inst_addr hold their value while out_valid && !out_ready.
REQ-026 clear: next edge empties FIFO, address counter = START_ADDR, err=0, err_count=0; request presented with clear is dropped; clear wins over simultaneous push/pop.

Reset
REQ-027 On rst_n=0 at an edge: out_valid=0, in_ready=1 the following cycle, inst=0, inst_addr=0, err=0, err_count=0, address counter=START_ADDR, occupancy=0.
REQ-028 Reset mid-transfer discards all buffered entries without completing them.

Configuration
REQ-029 Macro INST_ENC_RANGE_CHECK_EN defined: ADDI with imm[31:11] not all equal (outside -2048..2047) is illegal per REQ-022.
REQ-030 Macro undefined: no range check; imm truncated to imm[11:0], no error raised for range.

Verification
REQ-031 is_imm=0, alu_control=0010, rs1=1, rs2=2, rd=3 -> next cycle inst=32'h002081B3, inst_addr=START_ADDR.
REQ-032 is_imm=0, alu_control=0100, rs1=6, rs2=7, rd=5, then ADDI rd=1, rs1=0, imm=-1 with out_ready=1 -> 32'h407302B3 @ +0, 32'hFFF00093 @ +4.
REQ-033 out_ready=0, three back-to-back requests -> in_ready low after two accepts; third held; releasing out_ready drains in order with addresses +0,+4,+8.
REQ-034 ADDI rd=1, rs1=0, imm=2048 -> with macro: inst=32'h00000013, err=1, err_count=1; without: inst=32'h80000093, err=0.
REQ-035 alu_control=4'b1111 repeated 300 times -> err_count=8'hFF, all outputs 32'h00000013; then clear -> err=0, err_count=0, next inst_addr=START_ADDR.
REQ-036 START_ADDR=32'hFFFF_FFF8, three legal requests -> inst_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
